// File: rtl/fg_trapezoid_gen.sv
// Trapezoid/pulse generator with its own period counter, saturating rise/fall slopes,
// settings double-buffered at period boundaries, and a clamped signed output stage.
module fg_trapezoid_gen #(
  parameter int unsigned COUNTER_BITWIDTH  = 32,
  parameter int unsigned WAVEFORM_BITWIDTH = 16
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              clk_en_i,
  input  logic                              enable_i,
  input  logic [COUNTER_BITWIDTH-1:0]       period_i,
  input  logic [COUNTER_BITWIDTH-1:0]       on_time_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]      k_rise_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]      k_fall_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]      amplitude_i,
  input  logic signed [WAVEFORM_BITWIDTH:0] offset_i,
  input  logic                              invert_i,
  output logic signed [WAVEFORM_BITWIDTH:0] out_o,
  output logic                              period_start_o,
  output logic [2:0]                        state_o
);
  localparam int unsigned W  = WAVEFORM_BITWIDTH;
  localparam int unsigned CW = COUNTER_BITWIDTH;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRise = 3'd1,
    StOn   = 3'd2,
    StFall = 3'd3,
    StLow  = 3'd4
  } state_e;

  state_e            state_q, state_d, start_state;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]      val_q, val_d;
  logic              ps_q, ps_d;
  logic signed [W:0] out_q, out_d;

  // Shadow copies of the settings, only updated on a period-start tick
  logic [CW-1:0]     period_q, on_time_q;
  logic [W-1:0]      k_rise_q, k_fall_q, amp_q;
  logic signed [W:0] offset_q;
  logic              invert_q;
  logic              load;

  logic [W:0]          rise_sum;
  logic signed [W:0]   fall_diff;
  logic [W-1:0]        rise_val, fall_val, level_val;
  logic                period_end, on_end;
  logic signed [W+1:0] val_ext, sum;

  // Slopes are evaluated one bit wider so neither direction can wrap
  always_comb begin
    rise_sum  = {1'b0, val_q} + {1'b0, k_rise_q};
    fall_diff = $signed({1'b0, val_q}) - $signed({1'b0, k_fall_q});
    rise_val  = (k_rise_q == '0 || rise_sum >= {1'b0, amp_q}) ? amp_q : rise_sum[W-1:0];
    fall_val  = (k_fall_q == '0 || fall_diff[W] || fall_diff == '0) ? '0 : fall_diff[W-1:0];
  end

  always_comb begin
    val_ext = {2'b00, val_q};
    sum     = {offset_q[W], offset_q} + (invert_q ? -val_ext : val_ext);
    case (sum[W+1:W])
      2'b01:   out_d = {1'b0, {W{1'b1}}};
      2'b10:   out_d = {1'b1, {W{1'b0}}};
      default: out_d = sum[W:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    val_d       = val_q;
    ps_d        = 1'b0;
    load        = 1'b0;
    start_state = (on_time_i == '0) ? StLow : StRise;
    period_end  = (cnt_q == period_q - 1'b1);
    on_end      = (cnt_q == on_time_q - 1'b1);

    case (state_q)
      StRise:  level_val = rise_val;
      StOn:    level_val = amp_q;
      StFall:  level_val = fall_val;
      default: level_val = '0;
    endcase

    if (!enable_i || !(state_q inside {StIdle, StRise, StOn, StFall, StLow})) begin
      state_d = StIdle;
      cnt_d   = '0;
      val_d   = '0;
    end else if (state_q == StIdle) begin
      cnt_d = '0;
      val_d = '0;
      if (period_i != '0) begin
        load    = 1'b1;
        ps_d    = 1'b1;
        state_d = start_state;
      end
    end else begin
      val_d = level_val;
      if (period_end) begin
        cnt_d = '0;
        // A zero period reloaded at a boundary disables the generator
        if (period_i == '0) begin
          state_d = StIdle;
          val_d   = '0;
        end else begin
          load    = 1'b1;
          ps_d    = 1'b1;
          state_d = start_state;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
        case (state_q)
          StRise: begin
            if (on_end) state_d = StFall;
            else if (val_d == amp_q) state_d = StOn;
          end
          StOn: begin
            if (on_end) state_d = StFall;
          end
          StFall: begin
            if (val_d == '0) state_d = StLow;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      val_q     <= '0;
      ps_q      <= 1'b0;
      out_q     <= '0;
      period_q  <= '0;
      on_time_q <= '0;
      k_rise_q  <= '0;
      k_fall_q  <= '0;
      amp_q     <= '0;
      offset_q  <= '0;
      invert_q  <= 1'b0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      ps_q    <= ps_d;
      out_q   <= out_d;
      if (load) begin
        period_q  <= period_i;
        on_time_q <= on_time_i;
        k_rise_q  <= k_rise_i;
        k_fall_q  <= k_fall_i;
        amp_q     <= amplitude_i;
        offset_q  <= offset_i;
        invert_q  <= invert_i;
      end
    end
  end

  assign out_o          = out_q;
  assign period_start_o = ps_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_fg_trapezoid_gen.sv
// Bench for fg_trapezoid_gen: directed waveform scenarios plus randomized settings checked
// against a per-tick behavioural model of the generator.
module tb_fg_trapezoid_gen;
  localparam int CW = 16;
  localparam int W  = 8;
  localparam int S_IDLE = 0, S_RISE = 1, S_ON = 2, S_FALL = 3, S_LOW = 4;
  localparam int OUT_MAX = 255, OUT_MIN = -256;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              clk_en_i = 1'b0;
  logic              enable_i = 1'b0;
  logic [CW-1:0]     period_i = '0;
  logic [CW-1:0]     on_time_i = '0;
  logic [W-1:0]      k_rise_i = '0;
  logic [W-1:0]      k_fall_i = '0;
  logic [W-1:0]      amplitude_i = '0;
  logic signed [W:0] offset_i = '0;
  logic              invert_i = 1'b0;
  logic signed [W:0] out_o;
  logic              period_start_o;
  logic [2:0]        state_o;

  always #5 clk_i = ~clk_i;

  fg_trapezoid_gen #(
    .COUNTER_BITWIDTH (CW),
    .WAVEFORM_BITWIDTH(W)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .clk_en_i      (clk_en_i),
    .enable_i      (enable_i),
    .period_i      (period_i),
    .on_time_i     (on_time_i),
    .k_rise_i      (k_rise_i),
    .k_fall_i      (k_fall_i),
    .amplitude_i   (amplitude_i),
    .offset_i      (offset_i),
    .invert_i      (invert_i),
    .out_o         (out_o),
    .period_start_o(period_start_o),
    .state_o       (state_o)
  );

  int errors = 0;
  int checks = 0;

  // Model state: phase, tick counter, level, registered output, period-start flag, settings
  int m_state, m_cnt, m_val, m_out, m_ps;
  int m_p, m_n, m_kr, m_kf, m_a, m_off, m_inv;

  task automatic model_reset();
    m_state = S_IDLE; m_cnt = 0; m_val = 0; m_out = 0; m_ps = 0;
    m_p = 0; m_n = 0; m_kr = 0; m_kf = 0; m_a = 0; m_off = 0; m_inv = 0;
  endtask

  // Level at counter c of the reference trapezoid (P=20 N=10 kr=32 kf=64 A=100)
  function automatic int trap_val(input int c);
    if (c < 3) return 32 * (c + 1);
    if (c < 10) return 100;
    if (c == 10) return 36;
    return 0;
  endfunction

  task automatic setup(input int p, input int n, input int kr, input int kf, input int a,
                       input int off, input int inv);
    period_i    = p[CW-1:0];
    on_time_i   = n[CW-1:0];
    k_rise_i    = kr[W-1:0];
    k_fall_i    = kf[W-1:0];
    amplitude_i = a[W-1:0];
    offset_i    = off[W:0];
    invert_i    = inv[0];
  endtask

  // Advance one clock; on a tick the model applies the generator rules to the current inputs
  task automatic step(input bit ce);
    int ns, nc, nv, o, nps;
    bit ld;
    clk_en_i = ce;
    if (ce) begin
      o = m_off + (m_inv != 0 ? -m_val : m_val);
      if (o > OUT_MAX) o = OUT_MAX;
      if (o < OUT_MIN) o = OUT_MIN;
      ns = m_state; nc = m_cnt; nv = m_val; nps = 0; ld = 0;
      if (!enable_i) begin
        ns = S_IDLE; nc = 0; nv = 0;
      end else if (m_state == S_IDLE) begin
        nc = 0; nv = 0;
        if (period_i != 0) begin
          ld = 1; nps = 1; ns = (on_time_i == 0) ? S_LOW : S_RISE;
        end
      end else begin
        case (m_state)
          S_RISE:  nv = (m_kr == 0 || m_val + m_kr > m_a) ? m_a : m_val + m_kr;
          S_ON:    nv = m_a;
          S_FALL:  nv = (m_kf == 0 || m_val - m_kf < 0) ? 0 : m_val - m_kf;
          default: nv = 0;
        endcase
        if (m_cnt == m_p - 1) begin
          nc = 0;
          if (period_i == 0) begin
            ns = S_IDLE; nv = 0;
          end else begin
            ld = 1; nps = 1; ns = (on_time_i == 0) ? S_LOW : S_RISE;
          end
        end else begin
          nc = m_cnt + 1;
          if (m_state == S_RISE && m_cnt == m_n - 1) ns = S_FALL;
          else if (m_state == S_RISE && nv == m_a) ns = S_ON;
          else if (m_state == S_ON && m_cnt == m_n - 1) ns = S_FALL;
          else if (m_state == S_FALL && nv == 0) ns = S_LOW;
        end
      end
      if (ld) begin
        m_p = int'(period_i); m_n = int'(on_time_i); m_kr = int'(k_rise_i);
        m_kf = int'(k_fall_i); m_a = int'(amplitude_i); m_off = int'(offset_i);
        m_inv = int'(invert_i);
      end
      m_state = ns; m_cnt = nc; m_val = nv; m_out = o; m_ps = nps;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic go_idle();
    enable_i = 1'b0;
    step(1'b1);
    step(1'b1);
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; enable_i = 1'b1; clk_en_i = 1'b1;
    setup(20, 10, 32, 64, 100, 50, 0);
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (state_o !== 3'(S_IDLE)) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_o, S_IDLE); end
    checks++; if (out_o !== 9'sd0) begin errors++; $display("FAIL reset_out: got %0d want 0", out_o); end
    checks++; if (period_start_o !== 1'b0) begin errors++; $display("FAIL reset_ps: got %0b want 0", period_start_o); end
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1; enable_i = 1'b0;
  endtask

  task automatic test_period_zero();
    setup(0, 10, 32, 64, 100, 0, 0);
    enable_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step(1'b1);
      checks++; if (state_o !== 3'(S_IDLE)) begin errors++; $display("FAIL pzero_state j=%0d: got %0d want %0d", j, state_o, S_IDLE); end
      checks++; if (out_o !== 9'sd0) begin errors++; $display("FAIL pzero_out j=%0d: got %0d want 0", j, out_o); end
    end
  endtask

  task automatic test_trapezoid();
    int want;
    go_idle();
    setup(20, 10, 32, 64, 100, 0, 0);
    enable_i = 1'b1;
    step(1'b1);
    checks++; if (state_o !== 3'(S_RISE) || period_start_o !== 1'b1) begin errors++; $display("FAIL trap_start: got state %0d ps %0b want %0d 1", state_o, period_start_o, S_RISE); end
    for (int j = 1; j <= 45; j++) begin
      step(1'b1);
      if (j >= 2) begin
        want = trap_val((j - 2) % 20);
        checks++; if (out_o !== 9'(want)) begin errors++; $display("FAIL trap_out j=%0d: got %0d want %0d", j, out_o, want); end
      end
      checks++; if (period_start_o !== (j % 20 == 0)) begin errors++; $display("FAIL trap_ps j=%0d: got %0b want %0b", j, period_start_o, j % 20 == 0); end
      if (j == 4 || j == 10 || j == 12) begin
        want = (j == 4) ? S_ON : (j == 10) ? S_FALL : S_LOW;
        checks++; if (state_o !== 3'(want)) begin errors++; $display("FAIL trap_state j=%0d: got %0d want %0d", j, state_o, want); end
      end
      checks++; if (state_o !== 3'(m_state)) begin errors++; $display("FAIL trap_model_state j=%0d: got %0d want %0d", j, state_o, m_state); end
    end
  endtask

  task automatic test_square();
    int want;
    go_idle();
    setup(20, 10, 0, 0, 100, 0, 0);
    enable_i = 1'b1;
    step(1'b1);
    for (int j = 1; j <= 23; j++) begin
      step(1'b1);
      if (j >= 2) begin
        want = ((j - 2) % 20 < 10) ? 100 : 0;
        checks++; if (out_o !== 9'(want)) begin errors++; $display("FAIL square_out j=%0d: got %0d want %0d", j, out_o, want); end
      end
    end
  endtask

  task automatic test_truncated();
    int want;
    go_idle();
    setup(20, 2, 10, 64, 100, 0, 0);
    enable_i = 1'b1;
    step(1'b1);
    for (int j = 1; j <= 6; j++) begin
      step(1'b1);
      if (j >= 2) begin
        want = (j == 2) ? 10 : (j == 3) ? 20 : 0;
        checks++; if (out_o !== 9'(want)) begin errors++; $display("FAIL trunc_out j=%0d: got %0d want %0d", j, out_o, want); end
      end
      if (j == 2 || j == 3) begin
        want = (j == 2) ? S_FALL : S_LOW;
        checks++; if (state_o !== 3'(want)) begin errors++; $display("FAIL trunc_state j=%0d: got %0d want %0d", j, state_o, want); end
      end
    end
  endtask

  task automatic test_midperiod_change();
    go_idle();
    setup(20, 10, 0, 0, 100, 0, 0);
    enable_i = 1'b1;
    step(1'b1);
    for (int j = 1; j <= 32; j++) begin
      if (j == 6) begin
        amplitude_i = 8'd50;
        period_i    = 16'd10;
      end
      step(1'b1);
      if (j >= 6 && j <= 11) begin
        checks++; if (out_o !== 9'sd100) begin errors++; $display("FAIL mid_old_amp j=%0d: got %0d want 100", j, out_o); end
      end
      if (j >= 22) begin
        checks++; if (out_o !== 9'sd50) begin errors++; $display("FAIL mid_new_amp j=%0d: got %0d want 50", j, out_o); end
      end
      if (j >= 6) begin
        checks++; if (period_start_o !== (j == 20 || j == 30)) begin errors++; $display("FAIL mid_ps j=%0d: got %0b want %0b", j, period_start_o, j == 20 || j == 30); end
      end
    end
  endtask

  task automatic test_clk_en();
    int t;
    int want;
    go_idle();
    setup(20, 10, 32, 64, 100, 0, 0);
    enable_i = 1'b1;
    for (int cyc = 0; cyc < 75; cyc++) begin
      step(cyc % 3 == 0);
      t = cyc / 3;
      if (t >= 2) begin
        want = trap_val((t - 2) % 20);
        checks++; if (out_o !== 9'(want)) begin errors++; $display("FAIL clken_out cyc=%0d: got %0d want %0d", cyc, out_o, want); end
      end
      checks++; if (period_start_o !== (t % 20 == 0)) begin errors++; $display("FAIL clken_ps cyc=%0d: got %0b want %0b", cyc, period_start_o, t % 20 == 0); end
    end
  endtask

  task automatic test_clamp();
    go_idle();
    setup(20, 10, 0, 0, 100, 200, 0);
    enable_i = 1'b1;
    step(1'b1);
    for (int j = 1; j <= 6; j++) begin
      step(1'b1);
      if (j >= 2) begin
        checks++; if (out_o !== 9'sd255) begin errors++; $display("FAIL clamp_pos j=%0d: got %0d want 255", j, out_o); end
      end
    end
    go_idle();
    setup(20, 10, 0, 0, 100, -200, 1);
    enable_i = 1'b1;
    step(1'b1);
    for (int j = 1; j <= 6; j++) begin
      step(1'b1);
      if (j >= 2) begin
        checks++; if (out_o !== -9'sd256) begin errors++; $display("FAIL clamp_neg j=%0d: got %0d want -256", j, out_o); end
      end
    end
  endtask

  task automatic test_reset_mid_fall();
    go_idle();
    setup(20, 10, 32, 64, 100, 0, 0);
    enable_i = 1'b1;
    step(1'b1);
    for (int j = 1; j <= 11; j++) step(1'b1);
    checks++; if (state_o !== 3'(S_FALL)) begin errors++; $display("FAIL rst_pre_state: got %0d want %0d", state_o, S_FALL); end
    #2;
    rstn_i = 1'b0;
    #1;
    checks++; if (out_o !== 9'sd0) begin errors++; $display("FAIL rst_async_out: got %0d want 0", out_o); end
    checks++; if (state_o !== 3'(S_IDLE)) begin errors++; $display("FAIL rst_async_state: got %0d want %0d", state_o, S_IDLE); end
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
    step(1'b1);
    checks++; if (state_o !== 3'(S_RISE) || period_start_o !== 1'b1) begin errors++; $display("FAIL rst_restart: got state %0d ps %0b want %0d 1", state_o, period_start_o, S_RISE); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        setup(int'($urandom_range(1, 12)), int'($urandom_range(0, 14)),
              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255)),
              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 511)) - 256,
              int'($urandom_range(0, 1)));
      end
      enable_i = ($urandom_range(0, 39) != 0);
      step($urandom_range(0, 3) != 0);
      checks++; if (out_o !== 9'(m_out)) begin errors++; $display("FAIL rand_out i=%0d: got %0d want %0d", i, out_o, m_out); end
      checks++; if (state_o !== 3'(m_state)) begin errors++; $display("FAIL rand_state i=%0d: got %0d want %0d", i, state_o, m_state); end
      checks++; if (period_start_o !== 1'(m_ps)) begin errors++; $display("FAIL rand_ps i=%0d: got %0b want %0d", i, period_start_o, m_ps); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_period_zero();
    test_trapezoid();
    test_square();
    test_truncated();
    test_midperiod_change();
    test_clk_en();
    test_clamp();
    test_reset_mid_fall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
